// File: rtl/tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_arbiter_pkg
// Shared definitions for the TX arbiter slice: command width, TX header
// encodings, the reply-tracker entry layout and a helper that builds an entry.
// No ports (package).
// -----------------------------------------------------------------------------
package tx_arbiter_pkg;

    localparam int TX_CMD_BITS = 4;

    typedef enum logic [TX_CMD_BITS-1:0] {
        TX_HEADER_NOP      = 4'h0,
        TX_HEADER_READ_16  = 4'h1,
        TX_HEADER_WRITE_16 = 4'h2,
        TX_HEADER_READ_8   = 4'h3,
        TX_HEADER_WRITE_8  = 4'h4
    } tx_header_e;

    // One outstanding-reply slot: reply is expected, and who gets it.
    typedef struct packed {
        logic reply;
        logic is_sc;
    } reply_entry_t;

    localparam int REPLY_ENTRY_BITS = 2;

    // A read that expects no reply is tracked as an all-zero slot so that
    // popping it raises neither sc_rx nor pf_rx.
    function automatic reply_entry_t make_entry(input logic reply, input logic is_sc);
        reply_entry_t e;
        if (reply) begin
            e.reply = 1'b1;
            e.is_sc = is_sc;
        end else begin
            e.reply = 1'b0;
            e.is_sc = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_arbiter_if
// Bundles the prefetcher / scheduler request side, the memory-interface side
// and the grant/status flags of tx_arbiter.
//   slave  : arbiter view (requests and memory status in, TX command/flags out)
//   master : environment view (drives requests and memory status)
// Parameter IO_BITS : width of the serial TX/RX data path.
// -----------------------------------------------------------------------------
interface tx_arbiter_if
    import tx_arbiter_pkg::*;
#(
    parameter int IO_BITS = 2
) ();

    // prefetcher request
    logic                   pf_cmd_valid;
    logic [TX_CMD_BITS-1:0] pf_cmd;
    logic [IO_BITS-1:0]     pf_data;
    // scheduler request
    logic                   sc_cmd_valid;
    logic [TX_CMD_BITS-1:0] sc_cmd;
    logic [IO_BITS-1:0]     sc_data;
    logic                   sc_reply_wanted;
    logic                   sc_reserve;
    logic                   block_prefetch;
    logic                   write_pc;
    // memory interface
    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic [IO_BITS-1:0]     tx_data;
    logic                   tx_command_started;
    logic                   tx_active;
    logic                   rx_done;
    // grant and status flags
    logic                   sc_tx;
    logic                   pf_tx;
    logic                   sc_rx;
    logic                   pf_rx;
    logic                   prefetch_idle;
    logic                   tx_fetch;
    logic                   tx_jump;
    logic                   full;
    logic                   empty;

    modport slave (
        input  pf_cmd_valid, pf_cmd, pf_data,
        input  sc_cmd_valid, sc_cmd, sc_data, sc_reply_wanted,
        input  sc_reserve, block_prefetch, write_pc,
        input  tx_command_started, tx_active, rx_done,
        output tx_command_valid, tx_command, tx_data,
        output sc_tx, pf_tx, sc_rx, pf_rx, prefetch_idle,
        output tx_fetch, tx_jump, full, empty
    );

    modport master (
        output pf_cmd_valid, pf_cmd, pf_data,
        output sc_cmd_valid, sc_cmd, sc_data, sc_reply_wanted,
        output sc_reserve, block_prefetch, write_pc,
        output tx_command_started, tx_active, rx_done,
        input  tx_command_valid, tx_command, tx_data,
        input  sc_tx, pf_tx, sc_rx, pf_rx, prefetch_idle,
        input  tx_fetch, tx_jump, full, empty
    );

endinterface

// File: rtl/tx_arbiter_reply_fifo.sv
// -----------------------------------------------------------------------------
// reply_fifo
// Small FIFO tracking outstanding read replies in issue order.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   add         : push new_entry (ignored when full unless a pop happens too)
//   remove      : pop head (ignored when empty)
//   new_entry   : entry to push
//   last_entry  : current head entry (oldest outstanding)
//   empty, full : occupancy flags, decoded from the registered count
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// -----------------------------------------------------------------------------
module reply_fifo #(
    parameter int BITS  = 2,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            add,
    input  logic            remove,
    input  logic [BITS-1:0] new_entry,
    output logic [BITS-1:0] last_entry,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_add;
    logic w_do_remove;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty      = (r_count == {CNT_W{1'b0}});
    assign full       = (r_count == CNT_W'(DEPTH));
    assign last_entry = r_mem[r_rd_ptr];

    // Qualify requests: a pop frees a slot for a simultaneous push when full.
    always_comb begin
        w_do_remove = 1'b0;
        w_do_add    = 1'b0;
        if (remove && !empty) begin
            w_do_remove = 1'b1;
        end else begin
            w_do_remove = 1'b0;
        end
        if (add && (!full || w_do_remove)) begin
            w_do_add = 1'b1;
        end else begin
            w_do_add = 1'b0;
        end
    end

    // Storage and write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {BITS{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
        end else if (w_do_add) begin
            r_mem[r_wr_ptr] <= new_entry;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
    end

    // Read pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= {PTR_W{1'b0}};
        end else if (w_do_remove) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_do_add, w_do_remove})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Arbitrates the single TX command channel between the prefetcher and the
// scheduler and tracks which requester each outstanding read reply belongs to.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : tx_arbiter_if.slave -- requests, memory-interface handshake,
//            grant (sc_tx/pf_tx), reply routing (sc_rx/pf_rx) and status.
// Parameters: IO_BITS, MAX_OUTSTANDING, STARVE_LIMIT.
// Build option: define TX_ARB_FAIRNESS_EN to let the prefetcher in after
// STARVE_LIMIT consecutive scheduler starts; otherwise the scheduler has
// strict priority and STARVE_LIMIT has no effect.
// -----------------------------------------------------------------------------
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int IO_BITS         = 2,
    parameter int MAX_OUTSTANDING = 3,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic          clk,
    input  logic          reset,
    tx_arbiter_if.slave   bus
);

    logic                   r_sel;
    logic                   w_sc_req;
    logic                   w_starve_force;
    logic                   w_sc_wanted;
    logic                   w_sc_tx;
    logic                   w_grant_valid;
    logic [TX_CMD_BITS-1:0] w_cmd;
    logic [IO_BITS-1:0]     w_data;
    logic                   w_read16;
    logic                   w_push;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    reply_entry_t           w_new_entry;
    reply_entry_t           w_head;

    assign w_sc_req    = bus.sc_cmd_valid | bus.sc_reserve | bus.block_prefetch;
    assign w_sc_wanted = w_sc_req & ~w_starve_force;

`ifdef TX_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    // Count scheduler starts the prefetcher sat through; any prefetcher start clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (bus.tx_command_started) begin
            if (!w_sc_tx) begin
                r_starve_cnt <= {STARVE_W{1'b0}};
            end else if (bus.pf_cmd_valid && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end

    // A reservation or prefetch block always keeps the scheduler in front.
    assign w_starve_force = (r_starve_cnt == STARVE_W'(STARVE_LIMIT)) & bus.pf_cmd_valid
                          & ~bus.sc_reserve & ~bus.block_prefetch;
`else
    assign w_starve_force = 1'b0;
`endif

    // Grant register: follows the scheduler request while the link is idle
    // and holds the owner of the transfer in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= 1'b0;
        end else if (!bus.tx_active) begin
            r_sel <= w_sc_wanted;
        end
    end

    // Grant selection and command/data mux.
    always_comb begin
        w_sc_tx       = 1'b0;
        w_cmd         = bus.pf_cmd;
        w_data        = bus.pf_data;
        w_grant_valid = bus.pf_cmd_valid;
        if (bus.tx_active) begin
            w_sc_tx = r_sel;
        end else begin
            w_sc_tx = w_sc_wanted;
        end
        if (w_sc_tx) begin
            w_cmd         = bus.sc_cmd;
            w_data        = bus.sc_data;
            w_grant_valid = bus.sc_cmd_valid;
        end else begin
            w_cmd         = bus.pf_cmd;
            w_data        = bus.pf_data;
            w_grant_valid = bus.pf_cmd_valid;
        end
    end

    assign w_read16 = (w_cmd == TX_HEADER_READ_16);
    assign w_push   = bus.tx_command_started & w_read16;

    // Tracker entry for a starting read; a jump fetch is owned by the prefetcher path.
    always_comb begin
        w_new_entry = make_entry(1'b0, 1'b0);
        if (w_sc_tx) begin
            w_new_entry = make_entry(bus.sc_reply_wanted, ~bus.write_pc);
        end else begin
            w_new_entry = make_entry(1'b1, 1'b0);
        end
    end

    reply_fifo #(
        .BITS  (REPLY_ENTRY_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_reply_fifo (
        .clk        (clk),
        .reset      (reset),
        .add        (w_push),
        .remove     (bus.rx_done),
        .new_entry  (w_new_entry),
        .last_entry (w_head),
        .empty      (w_fifo_empty),
        .full       (w_fifo_full)
    );

    // Reads are held back when every reply slot is taken; writes never are.
    assign bus.tx_command_valid = w_grant_valid & ~(w_fifo_full & w_read16);
    assign bus.tx_command       = w_cmd;
    assign bus.tx_data          = w_data;

    assign bus.sc_tx         = w_sc_tx;
    assign bus.pf_tx         = ~w_sc_tx;
    assign bus.prefetch_idle = bus.tx_active ? r_sel : bus.block_prefetch;
    assign bus.tx_fetch      = ~w_sc_tx | bus.write_pc;
    assign bus.tx_jump       = bus.write_pc;

    assign bus.sc_rx = ~w_fifo_empty & w_head.reply &  w_head.is_sc;
    assign bus.pf_rx = ~w_fifo_empty & w_head.reply & ~w_head.is_sc;
    assign bus.full  = w_fifo_full;
    assign bus.empty = w_fifo_empty;

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
// Directed bench for tx_arbiter: arbitration, reply tracking/routing,
// backpressure, jump fetch, priority/fairness and mid-operation reset.
// Expected reply routing is held in a scoreboard queue filled when a read
// start is driven and drained when rx_done is driven.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    localparam int IO_BITS      = 2;
    localparam int MAX_OUT      = 3;
    localparam int STARVE_LIMIT = 4;
`ifdef TX_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tx_arbiter_if #(.IO_BITS(IO_BITS)) bus ();

    tx_arbiter #(
        .IO_BITS         (IO_BITS),
        .MAX_OUTSTANDING (MAX_OUT),
        .STARVE_LIMIT    (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0] sb_q [$];   // expected {sc_rx, pf_rx} per outstanding read

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_occ(input string tag);
        chk1({tag, "_empty"}, bus.empty, sb_q.size() == 0);
        chk1({tag, "_full"},  bus.full,  sb_q.size() == MAX_OUT);
    endtask

    // Drive rx_done and compare routing against the scoreboard head.
    task automatic rx_pop(input string tag);
        logic [1:0] e;
        e = 2'b00;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end
        chk1({tag, "_sc_rx"}, bus.sc_rx, e[1]);
        chk1({tag, "_pf_rx"}, bus.pf_rx, e[0]);
        bus.rx_done = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pf_cmd_valid       = 1'b0;
        bus.pf_cmd             = TX_HEADER_NOP;
        bus.pf_data            = 2'b00;
        bus.sc_cmd_valid       = 1'b0;
        bus.sc_cmd             = TX_HEADER_NOP;
        bus.sc_data            = 2'b00;
        bus.sc_reply_wanted    = 1'b0;
        bus.sc_reserve         = 1'b0;
        bus.block_prefetch     = 1'b0;
        bus.write_pc           = 1'b0;
        bus.tx_command_started = 1'b0;
        bus.tx_active          = 1'b0;
        bus.rx_done            = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        settle();

        // reset state
        chk1("rst_empty", bus.empty, 1'b1);
        chk1("rst_full",  bus.full,  1'b0);
        chk1("rst_sc_rx", bus.sc_rx, 1'b0);
        chk1("rst_pf_rx", bus.pf_rx, 1'b0);
        chk1("rst_pf_tx", bus.pf_tx, 1'b1);
        chk1("rst_sc_tx", bus.sc_tx, 1'b0);
        chk1("rst_fetch", bus.tx_fetch, 1'b1);
        chk1("rst_jump",  bus.tx_jump, 1'b0);
        chk1("rst_valid", bus.tx_command_valid, 1'b0);

        // idle arbitration: prefetcher alone, then scheduler arrives with tx_active
        bus.pf_cmd_valid = 1'b1;
        bus.pf_cmd       = TX_HEADER_READ_16;
        bus.pf_data      = 2'b10;
        bus.sc_cmd       = TX_HEADER_WRITE_16;
        bus.sc_data      = 2'b01;
        settle();
        chk1("pf_only_sc_tx", bus.sc_tx, 1'b0);
        chk1("pf_only_valid", bus.tx_command_valid, 1'b1);
        chk4("pf_only_cmd", bus.tx_command, TX_HEADER_READ_16);
        chk4("pf_only_data", {2'b00, bus.tx_data}, 4'h2);
        cyc();
        bus.sc_cmd_valid       = 1'b1;
        bus.tx_active          = 1'b1;
        bus.tx_command_started = 1'b1;
        settle();
        chk1("arb_frozen0", bus.sc_tx, 1'b0);
        chk1("no_bypass_empty", bus.empty, 1'b1);
        chk1("no_bypass_pf_rx", bus.pf_rx, 1'b0);
        sb_q.push_back(2'b01);
        cyc();
        bus.tx_command_started = 1'b0;
        settle();
        chk_occ("push1");
        chk1("push1_pf_rx", bus.pf_rx, 1'b1);
        chk1("arb_frozen1", bus.sc_tx, 1'b0);
        cyc();
        bus.tx_active = 1'b0;
        settle();
        chk1("arb_release", bus.sc_tx, 1'b1);
        chk4("arb_sc_cmd", bus.tx_command, TX_HEADER_WRITE_16);
        chk4("arb_sc_data", {2'b00, bus.tx_data}, 4'h1);
        chk1("arb_fetch", bus.tx_fetch, 1'b0);

        // routing and backpressure: sc reads with and without reply
        cyc();
        bus.sc_cmd             = TX_HEADER_READ_16;
        bus.sc_reply_wanted    = 1'b1;
        bus.tx_active          = 1'b1;
        bus.tx_command_started = 1'b1;
        settle();
        chk1("route_sc_grant", bus.sc_tx, 1'b1);
        sb_q.push_back(2'b10);
        cyc();
        bus.sc_reply_wanted = 1'b0;
        settle();
        chk_occ("push2");
        sb_q.push_back(2'b00);
        cyc();
        bus.tx_command_started = 1'b0;
        settle();
        chk_occ("push3");
        chk1("bp_read_blocked", bus.tx_command_valid, 1'b0);
        bus.sc_cmd = TX_HEADER_WRITE_16;
        settle();
        chk1("bp_write_ok", bus.tx_command_valid, 1'b1);
        bus.sc_cmd = TX_HEADER_READ_16;
        rx_pop("route0");
        cyc();
        settle();
        chk_occ("bp_release");
        chk1("bp_read_ok", bus.tx_command_valid, 1'b1);
        rx_pop("route1");
        cyc();
        settle();
        rx_pop("route2");
        cyc();
        bus.rx_done = 1'b0;
        settle();
        chk_occ("drained");

        // rx_done on an empty tracker is ignored
        rx_pop("rx_empty");
        cyc();
        bus.rx_done = 1'b0;
        settle();
        chk_occ("rx_empty_after");

        // jump fetch: scheduler read with write_pc goes to the prefetcher path
        bus.tx_active       = 1'b0;
        bus.write_pc        = 1'b1;
        bus.sc_reply_wanted = 1'b1;
        settle();
        chk1("jump_sc_tx", bus.sc_tx, 1'b1);
        chk1("jump_fetch", bus.tx_fetch, 1'b1);
        chk1("jump_jump",  bus.tx_jump, 1'b1);
        bus.tx_command_started = 1'b1;
        sb_q.push_back(2'b01);
        cyc();
        bus.tx_command_started = 1'b0;
        bus.write_pc           = 1'b0;
        settle();
        chk_occ("jump_push");

        // simultaneous pop and push (prefetcher read) keeps occupancy
        bus.sc_cmd_valid = 1'b0;
        settle();
        chk1("simul_pf_grant", bus.sc_tx, 1'b0);
        rx_pop("jump_route");
        bus.tx_command_started = 1'b1;
        sb_q.push_back(2'b01);
        cyc();
        bus.tx_command_started = 1'b0;
        bus.rx_done            = 1'b0;
        settle();
        chk_occ("simul");
        rx_pop("simul_route");
        cyc();
        bus.rx_done = 1'b0;
        settle();
        chk_occ("simul_drained");

        // prefetch_idle follows block_prefetch when idle, the grant when busy
        bus.block_prefetch = 1'b1;
        settle();
        chk1("pidle_idle", bus.prefetch_idle, 1'b1);
        chk1("pidle_sc_tx", bus.sc_tx, 1'b1);
        bus.tx_active = 1'b1;
        settle();
        chk1("pidle_busy", bus.prefetch_idle, 1'b0);
        bus.tx_active      = 1'b0;
        bus.block_prefetch = 1'b0;

        // priority / fairness with both requesters valid (writes, no tracking)
        bus.sc_cmd_valid       = 1'b1;
        bus.sc_cmd             = TX_HEADER_WRITE_16;
        bus.pf_cmd             = TX_HEADER_WRITE_16;
        bus.tx_command_started = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk1($sformatf("fair_start%0d", i), bus.sc_tx, FAIR ? (i != 4) : 1'b1);
            cyc();
        end
        bus.sc_reserve = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk1($sformatf("reserve_start%0d", i), bus.sc_tx, 1'b1);
            cyc();
        end
        bus.sc_reserve = 1'b0;
        settle();
        chk1("after_reserve", bus.sc_tx, !FAIR);
        bus.tx_command_started = 1'b0;

        // reset with two reads outstanding and the grant register set
        cyc();
        bus.sc_cmd_valid       = 1'b0;
        bus.pf_cmd             = TX_HEADER_READ_16;
        bus.tx_command_started = 1'b1;
        sb_q.push_back(2'b01);
        cyc();
        sb_q.push_back(2'b01);
        cyc();
        bus.tx_command_started = 1'b0;
        bus.sc_cmd_valid       = 1'b1;
        settle();
        chk_occ("pre_rst");
        cyc();
        bus.tx_active = 1'b1;
        settle();
        chk1("pre_rst_sel", bus.sc_tx, 1'b1);
        reset                  = 1'b1;
        bus.rx_done            = 1'b1;
        bus.tx_command_started = 1'b1;
        sb_q.delete();
        cyc();
        reset                  = 1'b0;
        bus.rx_done            = 1'b0;
        bus.tx_command_started = 1'b0;
        settle();
        chk1("rst_mid_sel", bus.sc_tx, 1'b0);
        chk_occ("rst_mid");
        rx_pop("rst_mid_rx");
        cyc();
        bus.rx_done = 1'b0;
        settle();
        chk_occ("rst_mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter IO_BITS, default 2, width of the serial TX/RX data path in bits.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 3, depth of the outstanding-reply tracker.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive scheduler starts before the prefetcher is forced in (only with fairness enabled).
REQ-004 SHALL have ports clk  in  1  clock; one clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports pf_cmd_valid  in  1 / pf_cmd  in  TX_CMD_BITS / pf_data  in  IO_BITS  prefetcher command request and payload.
REQ-006 SHALL have ports sc_cmd_valid  in  1 / sc_cmd  in  TX_CMD_BITS / sc_data  in  IO_BITS / sc_reply_wanted  in  1  scheduler command request, payload, and reply expectation.
REQ-007 SHALL have ports sc_reserve  in  1 / block_prefetch  in  1 / write_pc  in  1  scheduler TX reservation, prefetch block, and jump-fetch flag.
REQ-008 SHALL have ports tx_command_valid  out  1 / tx_command  out  TX_CMD_BITS / tx_data  out  IO_BITS  to the memory interface.
REQ-009 SHALL have ports tx_command_started  in  1 / tx_active  in  1 / rx_done  in  1  from the memory interface.
REQ-010 SHALL have ports sc_tx, pf_tx, sc_rx, pf_rx, prefetch_idle, tx_fetch, tx_jump, full, empty  out  1 each  grant and status flags.

Function
REQ-011 SHALL compute sc_wanted = sc_cmd_valid | sc_reserve | block_prefetch, gated by fairness (REQ-021).
REQ-012 SHALL hold a grant register sel, loaded with sc_wanted on every cycle with tx_active=0 and frozen while tx_active=1.
REQ-013 SHALL drive sc_tx = sel when tx_active=1, otherwise sc_wanted, and drive pf_tx = !sc_tx.
REQ-014 SHALL drive prefetch_idle = sel when tx_active=1, otherwise block_prefetch.
REQ-015 SHALL drive tx_fetch = pf_tx | write_pc and tx_jump = write_pc.
REQ-016 SHALL mux tx_command and tx_data from the granted requester and drive tx_command_valid = granted valid & !(full & tx_command==TX_HEADER_READ_16); writes are never blocked by full.
REQ-017 SHALL push entry {reply, is_sc} on tx_command_started & tx_command==TX_HEADER_READ_16, where reply = sc_tx ? sc_reply_wanted : 1 and is_sc = sc_tx & !write_pc; when reply=0 the pushed entry SHALL be 2'b00.
REQ-018 SHALL pop the head entry on rx_done; sc_rx = head.reply & head.is_sc and pf_rx = head.reply & !head.is_sc, both 0 when empty.
REQ-019 SHALL keep occupancy unchanged on simultaneous push and pop, ignore rx_done when empty, and assert full exactly at occupancy MAX_OUTSTANDING; the occupancy pointer SHALL wrap modulo MAX_OUTSTANDING, non-power-of-2 values included.
REQ-020 SHALL raise full/empty combinationally from registered occupancy, with no bypass: a push is visible in sc_rx/pf_rx the following cycle.
REQ-021 SHALL, with fairness, force sc_wanted=0 while starve_cnt==STARVE_LIMIT & pf_cmd_valid & !sc_reserve & !block_prefetch; sc_reserve and block_prefetch are never overridden.
REQ-022 SHALL increment starve_cnt (saturating) on each scheduler tx_command_started while pf_cmd_valid=1, and clear it on any prefetcher tx_command_started.

Reset
REQ-023 SHALL, on reset, clear sel to 0, occupancy and pointers to 0, and starve_cnt to 0, giving outputs empty=1, full=0, sc_rx=pf_rx=0, and pf_tx=1 when no scheduler input is high.
REQ-024 SHALL have reset dominate simultaneous push/pop and abandon any in-flight tracking; the memory interface is reset by the same reset.

Configuration
REQ-025 SHALL compile in the fairness logic (REQ-021, REQ-022) when TX_ARB_FAIRNESS_EN is defined; without it the scheduler has strict priority, starve_cnt is not instantiated, and STARVE_LIMIT is unused.

Structure
REQ-026 SHALL take TX_CMD_BITS and the TX_HEADER_* command encodings from the shared common header/package; no local redefinition.
REQ-027 SHALL instantiate the tracker as sub-module reply_fifo (BITS=2, DEPTH=MAX_OUTSTANDING, ports add/remove/new_entry/last_entry/empty/full).

Verification
REQ-028 SHALL cover idle arbitration: pf_cmd_valid=1 with sc_cmd_valid=0, then sc_cmd_valid=1 at the same cycle as tx_active=1 -> sc_tx stays 0 until tx_active falls, then sc_tx=1 the same cycle.
REQ-029 SHALL cover backpressure: 3 READ_16 starts with no rx_done -> full=1 and tx_command_valid=0 for READ_16; a write command is still valid; one rx_done -> full=0 the next cycle.
REQ-030 SHALL cover routing: push order pf, sc(reply=1), sc(reply=0) -> successive rx_done pulses give pf_rx, sc_rx, then neither.
REQ-031 SHALL cover the jump fetch: write_pc=1 with scheduler READ_16 -> tx_fetch=1, tx_jump=1, and entry routed to pf_rx.
REQ-032 SHALL cover fairness (macro defined, STARVE_LIMIT=4): both requesters valid continuously -> the 5th start is a prefetcher start; with sc_reserve=1 held, the scheduler keeps the grant.
REQ-033 SHALL cover reset mid-operation: 2 entries outstanding, reset=1 for one cycle -> empty=1, sel=0, and a subsequent rx_done is ignored.
